// File: rtl/alu_mul_seq_if.sv
// Bundle of the multiplier request/result handshake and the borrowed ALU port.
// The slave side is the sequencer; the master side is the requester plus the shared ALU.
interface alu_mul_seq_if #(parameter int W = 32);
  logic           start;
  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic [2:0]     alu_control;
  logic [W-1:0]   alu_A;
  logic [W-1:0]   alu_B;
  logic [W-1:0]   alu_out;
  logic           alu_C;

  modport master (
    output start, a_in, b_in, alu_out, alu_C,
    input  busy, done, product, alu_control, alu_A, alu_B
  );

  modport slave (
    input  start, a_in, b_in, alu_out, alu_C,
    output busy, done, product, alu_control, alu_A, alu_B
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier that borrows the datapath ALU for one ADD per step.
//   state | meaning
//   IDLE  | waiting for start; product holds last result
//   RUN   | W shift-add steps, ALU owned by this block
//   DONE  | one-cycle result pulse; start here is accepted
module alu_mul_seq #(
  parameter int W = 32
) (
  input logic         clk,
  input logic         reset,
  alu_mul_seq_if.slave bus
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   mcand;
  logic [W-1:0]   acc_hi;
  logic [W-1:0]   acc_lo;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] product;
  logic [2*W-1:0] acc_nxt;
  logic           load;
  logic           step;
  logic           last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        mcand  <= bus.a_in;
        acc_lo <= bus.b_in;
        acc_hi <= '0;
        cnt    <= '0;
      end else if (step) begin
        {acc_hi, acc_lo} <= acc_nxt;
        cnt              <= cnt + 1'b1;
        if (last) product <= acc_nxt;
      end
    end
  end

  // Carry of the add comes back from the shared ALU and becomes the new top bit.
  always_comb begin
    if (acc_lo[0]) acc_nxt = {bus.alu_C, bus.alu_out, acc_lo[W-1:1]};
    else           acc_nxt = {1'b0, acc_hi, acc_lo[W-1:1]};
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(W - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.product     = product;
  assign bus.alu_control = 3'b000;
  assign bus.alu_A       = acc_hi;
  assign bus.alu_B       = mcand;
endmodule
